// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter with a one-deep holding register in front of the shifter.
// txempty reports holding-register status and is the load handshake for the upstream sequencer.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] txdata,
  input  logic                 ldtxdata,
  output logic                 txempty,
  output logic                 txidle,
  output logic                 overrun,
  output logic                 txd
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic [BAUD_W-1:0]    baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic                 hold_full, hold_full_n;
  logic                 txd_r, txd_n;
  logic                 ovr_r, ovr_n;
  logic                 idle_r, idle_n;
  logic                 baud_done;
  logic                 transfer;

  assign baud_done = (baud_cnt == BAUD_LAST);
  // Hold drains into the shifter when idle or exactly as the stop bit ends (no idle gap).
  assign transfer  = hold_full && ((state == IDLE) || ((state == STOP) && baud_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (transfer) state_n = START;
      START:   if (baud_done) state_n = DATA;
      DATA:    if (baud_done && (bit_cnt == BIT_LAST)) state_n = STOP;
      STOP:    if (baud_done) state_n = hold_full ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_n  = baud_done ? '0 : baud_cnt + 1'b1;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    txd_n       = txd_r;
    hold_n      = hold;
    hold_full_n = hold_full;
    ovr_n       = ovr_r;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
      end
      START: if (baud_done) begin
        txd_n     = shift[0];
        bit_cnt_n = '0;
      end
      DATA: if (baud_done) begin
        if (bit_cnt == BIT_LAST) begin
          txd_n = 1'b1;
        end else begin
          shift_n   = shift >> 1;
          txd_n     = shift_n[0];
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    if (transfer) begin
      shift_n     = hold;
      txd_n       = 1'b0;
      baud_cnt_n  = '0;
      hold_full_n = 1'b0;
    end
    // A load coinciding with a transfer refills the hold; otherwise a full hold drops it.
    if (ldtxdata) begin
      if (!hold_full || transfer) begin
        hold_n      = txdata;
        hold_full_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end
    idle_n = (state_n == IDLE) && !hold_full_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      txd_r     <= 1'b1;
      ovr_r     <= 1'b0;
      idle_r    <= 1'b1;
    end else begin
      baud_cnt  <= baud_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      txd_r     <= txd_n;
      ovr_r     <= ovr_n;
      idle_r    <= idle_n;
    end
  end

  assign txd     = txd_r;
  assign txempty = !hold_full;
  assign txidle  = idle_r;
  assign overrun = ovr_r;

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Serial UART transmitter directly downstream of the table-sequencing FSM.
- Accepts a byte on txdata when ldtxdata is pulsed, holds it in a one-deep holding register and reports holding-register status on txempty.
- Shifts the byte out on txd as an 8N1 frame (start, 8 data LSB-first, stop).
- txempty is the handshake the upstream FSM waits on before loading its next byte.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 2.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- txdata  input  DATA_BITS  byte to transmit, sampled when ldtxdata=1
- ldtxdata  input  1  single-cycle load strobe
- txempty  output  1  1 = holding register empty, a new byte may be loaded
- txidle  output  1  1 = shifter idle and holding register empty (line quiet)
- overrun  output  1  sticky; set when a load is dropped
- txd  output  1  serial line, idle high

Behaviour:
- Reset (async, rst_n=0): txd=1, txempty=1, txidle=1, overrun=0, state=IDLE, counters=0, holding register cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, STOP.
  - Bit counter counts 0..DATA_BITS-1.
  - Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- Load (edge E, ldtxdata=1, holding empty): hold<=txdata, txempty=0 after E.
- Transfer when holding full and either:
  - state=IDLE, or
  - state=STOP with baud counter at CLKS_PER_BIT-1.
- On the transfer edge: shift<=hold, state<=START, txd<=0, baud counter<=0, hold_full<=0, so txempty=1 after that edge.
- From IDLE, a load at edge E gives transfer at E+1: txempty is low for exactly one cycle and txd falls after E+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
  - START -> DATA: txd<=shift[0].
  - DATA: shift right each bit; after DATA_BITS bits -> STOP, txd<=1.
  - STOP end: -> START if holding full (back-to-back, no idle gap), else -> IDLE.
- Frame length is 10*CLKS_PER_BIT cycles for DATA_BITS=8.
- Simultaneous load and transfer on the same edge: shifter takes the old hold, hold takes the new txdata, and hold_full stays 1 (txempty stays 0).
- Load while holding full and no transfer that edge: byte dropped, hold unchanged, overrun<=1. overrun clears only on reset.
- txidle = (state==IDLE) && !hold_full, registered.
- txdata is ignored when ldtxdata=0.
- Reset mid-frame: txd returns to 1 immediately (async), the frame is aborted and any held byte is lost.

Test Plan:
(All scenarios use CLKS_PER_BIT=4, DATA_BITS=8.)
- Reset: assert rst_n=0 mid-cycle -> txd=1, txempty=1, txidle=1, overrun=0 without waiting for a clock edge.
- Single byte: ldtxdata pulse with txdata=8'hA5 at edge E ->
  - txempty=0 after E, back to 1 after E+1;
  - txd after E+1, each value held 4 cycles: 0, then 1,0,1,0,0,1,0,1, then 1;
  - txidle=1 exactly 40 cycles after E+1.
- Back-to-back: load 8'h55, wait for txempty=1, load 8'h0F during the first frame ->
  - the 8'h0F start bit begins on the cycle right after the 8'h55 stop bit's 4th cycle;
  - total 80 cycles with no idle-high gap.
- Overrun: load 8'h11, then 8'h22 while txempty=0 (shifter busy), then 8'h33 before the transfer ->
  - overrun=1;
  - transmitted sequence is 8'h11 then 8'h22; 8'h33 is never sent.
- Reset mid-frame: rst_n=0 during the DATA bit 3 of 8'hFF ->
  - txd=1 and state IDLE immediately;
  - after release, a new load of 8'h3C transmits cleanly with the correct bit sequence.
- Upstream pairing: drive with a model of the table FSM (load, wait for txempty, load, wait for txempty) -> both bytes appear on txd in order, and txidle rises exactly once, after the second stop bit.
